ws_line_sram_bridge: RTL and testbench

Parametrised Wishbone-slave line adapter that turns one cache-line request (LINE_WORDS × WORD_W bits) into a burst of single-word accesses on the word-wide SRAM controller bus. It sits between the cache/memory crossbar and the SRAM controller, replacing the fixed 16×32-bit adapter. Over that adapter it adds configurable line geometry, pipelined reads with a fixed SRAM read latency, skipping of fully masked write words, and abort on `ws_cyc` drop.

---
 rtl/ws_bridge_pkg.sv | 24 ++
 rtl/ws_line_sram_bridge_rd_lat_pipe.sv | 50 +++++
 rtl/ws_line_sram_bridge.sv | 170 +++++++++++++++++
 tb/tb_ws_line_sram_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_bridge_pkg.sv
// Shared definitions for the Wishbone line to SRAM word bridge:
// FSM state encoding and geometry helpers.
package ws_bridge_pkg;

  // Bridge FSM states; the encoding is exported on dbg_state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ACK   = 3'd4
  } bridge_state_e;

  // Bytes per SRAM word.
  function automatic int byte_w(input int word_w);
    return word_w / 8;
  endfunction

  // Number of byte-offset bits inside one cache line.
  function automatic int off_bits(input int line_words, input int word_w);
    return $clog2(line_words * (word_w / 8));
  endfunction

endpackage

// File: rtl/ws_line_sram_bridge_rd_lat_pipe.sv
// Valid/index delay line that tags returning SRAM read data with the
// word index of the beat that requested it, DEPTH cycles later.
module rd_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 4
) (
  input  logic             clkCPU,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push_vld,
  input  logic [IDX_W-1:0] push_idx,
  output logic             pop_vld,
  output logic [IDX_W-1:0] pop_idx,
  output logic             pending
);

  logic [DEPTH-1:0] vld_reg;
  logic [IDX_W-1:0] idx_reg [DEPTH];

  // Shift valid and index one stage per cycle; clr drops every in-flight entry.
  always_ff @(posedge clkCPU or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int i = 0; i < DEPTH; i++) idx_reg[i] <= '0;
    end else begin
      if (clr) begin
        vld_reg <= '0;
      end else begin
        vld_reg[0] <= push_vld;
        for (int i = 1; i < DEPTH; i++) vld_reg[i] <= vld_reg[i-1];
      end
      idx_reg[0] <= push_idx;
      for (int i = 1; i < DEPTH; i++) idx_reg[i] <= idx_reg[i-1];
    end
  end

  assign pop_vld = vld_reg[DEPTH-1];
  assign pop_idx = idx_reg[DEPTH-1];

  // pending: entries that will still be in the pipe after the current edge,
  // i.e. everything except the entry emerging this cycle.
  generate
    if (DEPTH > 1) begin : g_pending
      assign pending = |vld_reg[DEPTH-2:0];
    end else begin : g_no_pending
      assign pending = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ws_line_sram_bridge.sv
// Wishbone-slave line adapter: splits one cache-line request into a burst
// of single-word SRAM beats. Writes skip fully masked words, reads are
// pipelined against a fixed SRAM latency, and dropping ws_cyc aborts.
module ws_line_sram_bridge
  import ws_bridge_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                           clkCPU,
  input  logic                           rst_n,
  input  logic [ADDR_W-1:0]              ws_addr,
  input  logic [LINE_WORDS*WORD_W-1:0]   ws_din,
  input  logic [LINE_WORDS*WORD_W/8-1:0] ws_dm,
  input  logic                           ws_cyc,
  input  logic                           ws_stb,
  input  logic                           ws_we,
  output logic                           ws_ack,
  output logic [LINE_WORDS*WORD_W-1:0]   ws_dout,
  output logic [ADDR_W-1:0]              sramAddr,
  output logic [WORD_W-1:0]              sramInData,
  output logic [WORD_W/8-1:0]            sramDm,
  output logic                           sramStb,
  input  logic [WORD_W-1:0]              sramOutData,
  input  logic                           sramNak,
  output logic [2:0]                     dbg_state
);

  localparam int BYTES = byte_w(WORD_W);
  localparam int OFF   = off_bits(LINE_WORDS, WORD_W);
  localparam int IW    = $clog2(LINE_WORDS);
  localparam int CW    = IW + 1;  // one spare bit so the index never aliases
  localparam logic [ADDR_W-1:0] OFF_MASK = (ADDR_W'(1) << OFF) - ADDR_W'(1);

  bridge_state_e state_reg, state_next;
  logic [CW-1:0]                  idx_reg, idx_next;
  logic [ADDR_W-1:0]              base_reg;
  logic [LINE_WORDS*WORD_W-1:0]   din_reg;
  logic [LINE_WORDS*BYTES-1:0]    dm_reg;
  logic                           load;
  logic                           pipe_clr;

  logic [WORD_W-1:0] din_words [LINE_WORDS];
  logic [BYTES-1:0]  dm_words  [LINE_WORDS];
  logic [WORD_W-1:0] dout_reg  [LINE_WORDS];

  logic [IW-1:0]     idx_lo;
  logic [BYTES-1:0]  cur_dm;
  logic              last_word;
  logic              abort;
  logic              wr_beat;
  logic              rd_beat;
  logic              pop_vld;
  logic [IW-1:0]     pop_idx;
  logic              pending;

  // Word views of the latched line and of the returned read line.
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
      assign din_words[gi] = din_reg[gi*WORD_W +: WORD_W];
      assign dm_words[gi]  = dm_reg[gi*BYTES +: BYTES];
      assign ws_dout[gi*WORD_W +: WORD_W] = dout_reg[gi];
    end
  endgenerate

  assign idx_lo    = idx_reg[IW-1:0];
  assign cur_dm    = dm_words[idx_lo];
  assign last_word = (idx_reg == CW'(LINE_WORDS - 1));
  assign abort     = !ws_cyc && (state_reg == ST_WRITE || state_reg == ST_READ ||
                                 state_reg == ST_DRAIN);
  assign wr_beat   = (state_reg == ST_WRITE) && (|cur_dm);
  assign rd_beat   = (state_reg == ST_READ);

  // SRAM side is decoded from registered state, so it holds under nak and
  // falls to zero asynchronously with reset.
  assign sramStb    = wr_beat || rd_beat;
  assign sramAddr   = sramStb ? base_reg + ADDR_W'(idx_reg) * ADDR_W'(BYTES) : '0;
  assign sramDm     = wr_beat ? cur_dm : '0;
  assign sramInData = wr_beat ? din_words[idx_lo] : '0;
  assign ws_ack     = (state_reg == ST_ACK);
  assign dbg_state  = state_reg;

  // Next-state and beat-index logic; abort overrides any progress.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load       = 1'b0;
    pipe_clr   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ws_cyc && ws_stb) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = ws_we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        // A fully masked word is skipped without waiting on nak.
        if (!(|cur_dm) || !sramNak) begin
          idx_next = idx_reg + CW'(1);
          if (last_word) state_next = ST_ACK;
        end
      end
      ST_READ: begin
        if (!sramNak) begin
          idx_next = idx_reg + CW'(1);
          if (last_word) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!pending) state_next = ST_ACK;
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      pipe_clr   = 1'b1;
    end
  end

  // FSM state, beat index and the request latched at acceptance.
  always_ff @(posedge clkCPU or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      base_reg  <= '0;
      din_reg   <= '0;
      dm_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (load) begin
        base_reg <= ws_addr & ~OFF_MASK;
        din_reg  <= ws_din;
        dm_reg   <= ws_dm;
      end
    end
  end

  rd_lat_pipe #(
    .DEPTH(RD_LAT),
    .IDX_W(IW)
  ) u_rd_lat_pipe (
    .clkCPU  (clkCPU),
    .rst_n   (rst_n),
    .clr     (pipe_clr),
    .push_vld(rd_beat && !sramNak),
    .push_idx(idx_lo),
    .pop_vld (pop_vld),
    .pop_idx (pop_idx),
    .pending (pending)
  );

  // Store returning read words into the line at the index they were tagged with.
  always_ff @(posedge clkCPU or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) dout_reg[i] <= '0;
    end else if (pop_vld && !pipe_clr) begin
      dout_reg[pop_idx] <= sramOutData;
    end
  end

endmodule

// File: tb/tb_ws_line_sram_bridge.sv
// Directed bench for ws_line_sram_bridge: three instances (default geometry
// with RD_LAT=1, default geometry with RD_LAT=3 and nak, 64-bit x 8 words),
// each attached to a small behavioural SRAM model.
module tb_ws_line_sram_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: 32b x 16, RD_LAT=1, no nak ----------------
  logic [31:0]  addr_a;  logic [511:0] din_a;  logic [63:0] dm_a;
  logic cyc_a, stb_a, we_a, ack_a;
  logic [511:0] dout_a;  logic [31:0] saddr_a; logic [31:0] sdin_a;
  logic [3:0]   sdm_a;   logic sstb_a;         logic [31:0] sdout_a;
  logic nak_a;           logic [2:0] dbg_a;
  assign nak_a = 1'b0;

  ws_line_sram_bridge #(.WORD_W(32), .LINE_WORDS(16), .ADDR_W(32), .RD_LAT(1)) dut_a (
    .clkCPU(clk), .rst_n(rst_n), .ws_addr(addr_a), .ws_din(din_a), .ws_dm(dm_a),
    .ws_cyc(cyc_a), .ws_stb(stb_a), .ws_we(we_a), .ws_ack(ack_a), .ws_dout(dout_a),
    .sramAddr(saddr_a), .sramInData(sdin_a), .sramDm(sdm_a), .sramStb(sstb_a),
    .sramOutData(sdout_a), .sramNak(nak_a), .dbg_state(dbg_a));

  // ---------------- instance B: 32b x 16, RD_LAT=3, nak on 0x2014 ----------
  logic [31:0]  addr_b;  logic [511:0] din_b;  logic [63:0] dm_b;
  logic cyc_b, stb_b, we_b, ack_b;
  logic [511:0] dout_b;  logic [31:0] saddr_b; logic [31:0] sdin_b;
  logic [3:0]   sdm_b;   logic sstb_b;         logic [31:0] sdout_b;
  logic nak_b;           logic [2:0] dbg_b;
  int nak_cnt_b = 0;

  ws_line_sram_bridge #(.WORD_W(32), .LINE_WORDS(16), .ADDR_W(32), .RD_LAT(3)) dut_b (
    .clkCPU(clk), .rst_n(rst_n), .ws_addr(addr_b), .ws_din(din_b), .ws_dm(dm_b),
    .ws_cyc(cyc_b), .ws_stb(stb_b), .ws_we(we_b), .ws_ack(ack_b), .ws_dout(dout_b),
    .sramAddr(saddr_b), .sramInData(sdin_b), .sramDm(sdm_b), .sramStb(sstb_b),
    .sramOutData(sdout_b), .sramNak(nak_b), .dbg_state(dbg_b));

  // ---------------- instance C: 64b x 8, RD_LAT=1, no nak -----------------
  logic [31:0]  addr_c;  logic [511:0] din_c;  logic [63:0] dm_c;
  logic cyc_c, stb_c, we_c, ack_c;
  logic [511:0] dout_c;  logic [31:0] saddr_c; logic [63:0] sdin_c;
  logic [7:0]   sdm_c;   logic sstb_c;         logic [63:0] sdout_c;
  logic nak_c;           logic [2:0] dbg_c;
  assign nak_c = 1'b0;

  ws_line_sram_bridge #(.WORD_W(64), .LINE_WORDS(8), .ADDR_W(32), .RD_LAT(1)) dut_c (
    .clkCPU(clk), .rst_n(rst_n), .ws_addr(addr_c), .ws_din(din_c), .ws_dm(dm_c),
    .ws_cyc(cyc_c), .ws_stb(stb_c), .ws_we(we_c), .ws_ack(ack_c), .ws_dout(dout_c),
    .sramAddr(saddr_c), .sramInData(sdin_c), .sramDm(sdm_c), .sramStb(sstb_c),
    .sramOutData(sdout_c), .sramNak(nak_c), .dbg_state(dbg_c));

  // ---------------- SRAM models ----------------
  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] mem_b [logic [31:0]];
  logic [63:0] mem_c [logic [31:0]];
  logic [31:0] wlog_a[$], rlog_a[$], rlog_b[$], wlog_c[$], rlog_c[$];
  logic [31:0] rp_b [3];

  // Model A: byte-masked writes, read data one cycle after acceptance.
  always @(posedge clk) begin : m_a
    logic [31:0] w;
    sdout_a <= 32'hDEADBEEF;
    if (sstb_a && !nak_a) begin
      if (sdm_a != 4'h0) begin
        wlog_a.push_back(saddr_a);
        w = mem_a.exists(saddr_a) ? mem_a[saddr_a] : 32'h0;
        for (int b = 0; b < 4; b++) if (sdm_a[b]) w[b*8 +: 8] = sdin_a[b*8 +: 8];
        mem_a[saddr_a] = w;
      end else begin
        rlog_a.push_back(saddr_a);
        sdout_a <= mem_a.exists(saddr_a) ? mem_a[saddr_a] : 32'h0;
      end
    end
  end

  // Model B: read-only, three-cycle data latency, nak held 2 cycles on 0x2014.
  assign nak_b = sstb_b && (saddr_b == 32'h2014) && (nak_cnt_b < 2);
  always @(posedge clk) begin : m_b
    if (nak_b) nak_cnt_b <= nak_cnt_b + 1;
    rp_b[0] <= 32'hDEADBEEF;
    if (sstb_b && !nak_b && sdm_b == 4'h0) begin
      rlog_b.push_back(saddr_b);
      rp_b[0] <= mem_b.exists(saddr_b) ? mem_b[saddr_b] : 32'h0;
    end
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end
  assign sdout_b = rp_b[2];

  // Model C: 64-bit words, byte-masked writes, one-cycle read latency.
  always @(posedge clk) begin : m_c
    logic [63:0] w;
    sdout_c <= 64'hDEADBEEF_DEADBEEF;
    if (sstb_c && !nak_c) begin
      if (sdm_c != 8'h0) begin
        wlog_c.push_back(saddr_c);
        w = mem_c.exists(saddr_c) ? mem_c[saddr_c] : 64'h0;
        for (int b = 0; b < 8; b++) if (sdm_c[b]) w[b*8 +: 8] = sdin_c[b*8 +: 8];
        mem_c[saddr_c] = w;
      end else begin
        rlog_c.push_back(saddr_c);
        sdout_c <= mem_c.exists(saddr_c) ? mem_c[saddr_c] : 64'h0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one line request on instance inst and return the number of
  // negedges after the acceptance edge at which ws_ack was seen (-1 = none).
  task automatic req(input int inst, input logic we, input logic [31:0] addr,
                     input logic [511:0] din, input logic [63:0] dm, output int lat);
    @(negedge clk);
    case (inst)
      0: begin cyc_a = 1; stb_a = 1; we_a = we; addr_a = addr; din_a = din; dm_a = dm; end
      1: begin cyc_b = 1; stb_b = 1; we_b = we; addr_b = addr; din_b = din; dm_b = dm; end
      default: begin cyc_c = 1; stb_c = 1; we_c = we; addr_c = addr; din_c = din; dm_c = dm; end
    endcase
    @(posedge clk); #1;
    stb_a = 0; stb_b = 0; stb_c = 0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if ((inst == 0 && ack_a) || (inst == 1 && ack_b) || (inst == 2 && ack_c)) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    cyc_a = 0; cyc_b = 0; cyc_c = 0;
  endtask

  // Bound on total simulated time.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [511:0] line_a5, line_5a, line_mix, line_b0, line_c3, line_c64;
  logic [63:0]  dm_all, dm_39;
  int lat, n0, found;

  initial begin
    for (int i = 0; i < 16; i++) begin
      line_a5[i*32 +: 32]  = 32'hA500_0000 + i;
      line_5a[i*32 +: 32]  = 32'h5A00_0000 + i;
      line_mix[i*32 +: 32] = (i == 3 || i == 9) ? 32'h5A00_0000 + i : 32'hA500_0000 + i;
      line_b0[i*32 +: 32]  = 32'hB000_0000 + i;
      line_c3[i*32 +: 32]  = 32'hC300_0000 + i;
      mem_b[32'h2000 + 4*i] = 32'hB000_0000 + i;
    end
    for (int i = 0; i < 8; i++) line_c64[i*64 +: 64] = 64'h1122_3344_0000_0000 + i;
    dm_all = 64'hFFFF_FFFF_FFFF_FFFF;
    dm_39  = 64'h0000_00F0_0000_F000;

    rst_n = 0;
    cyc_a = 0; stb_a = 0; we_a = 0; addr_a = 0; din_a = 0; dm_a = 0;
    cyc_b = 0; stb_b = 0; we_b = 0; addr_b = 0; din_b = 0; dm_b = 0;
    cyc_c = 0; stb_c = 0; we_c = 0; addr_c = 0; din_c = 0; dm_c = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", ack_a, 0);
    chk("reset_stb", sstb_a, 0);
    chk("reset_dm", sdm_a, 0);
    chk("reset_addr", saddr_a, 0);
    chk("reset_indata", sdin_a, 0);
    chk("reset_dout", dout_a, 0);
    chk("reset_state", dbg_a, 3'd0);
    rst_n = 1;

    // Full-line write of 0x1000.
    n0 = wlog_a.size();
    req(0, 1'b1, 32'h1000, line_a5, dm_all, lat);
    $display("write 0x1000 full: ack latency %0d", lat);
    chk("wr_full_lat", lat, 17);
    chk("wr_full_beats", wlog_a.size() - n0, 16);
    for (int i = 0; i < 16; i++) chk("wr_full_addr", wlog_a[n0+i], 32'h1000 + 4*i);

    // Read it back.
    req(0, 1'b0, 32'h1000, 512'h0, 64'h0, lat);
    $display("read 0x1000: ack latency %0d", lat);
    chk("rd_lat", lat, 18);
    chk("rd_data", dout_a, line_a5);

    // Write with only words 3 and 9 enabled.
    n0 = wlog_a.size();
    req(0, 1'b1, 32'h1000, line_5a, dm_39, lat);
    $display("write 0x1000 words 3,9: ack latency %0d", lat);
    chk("wr_mask_lat", lat, 17);
    chk("wr_mask_beats", wlog_a.size() - n0, 2);
    chk("wr_mask_addr0", wlog_a[n0], 32'h100C);
    chk("wr_mask_addr1", wlog_a[n0+1], 32'h1024);

    // Unaligned read address; also confirms the masked merge.
    n0 = rlog_a.size();
    req(0, 1'b0, 32'h1034, 512'h0, 64'h0, lat);
    $display("read 0x1034 unaligned: ack latency %0d", lat);
    chk("unal_lat", lat, 18);
    chk("unal_first_addr", rlog_a[n0], 32'h1000);
    chk("unal_last_addr", rlog_a[n0+15], 32'h103C);
    chk("unal_data", dout_a, line_mix);

    // RD_LAT=3 with 2 nak cycles on beat 5.
    req(1, 1'b0, 32'h2000, 512'h0, 64'h0, lat);
    $display("read 0x2000 lat3 nak2: ack latency %0d", lat);
    chk("nak_lat", lat, 22);
    chk("nak_data", dout_b, line_b0);
    chk("nak_cycles", nak_cnt_b, 2);
    chk("nak_beats", rlog_b.size(), 16);

    // Prepare a second line, then abort a read at beat 7.
    req(0, 1'b1, 32'h3000, line_c3, dm_all, lat);
    $display("write 0x3000 full: ack latency %0d", lat);
    chk("wr3_lat", lat, 17);
    n0 = rlog_a.size();
    @(negedge clk);
    cyc_a = 1; stb_a = 1; we_a = 0; addr_a = 32'h1000;
    @(posedge clk); #1;
    stb_a = 0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sstb_a && saddr_a == 32'h101C) begin
        found = 1;
        break;
      end
    end
    chk("abort_reach_beat7", found, 1);
    cyc_a = 0;
    @(posedge clk); #1;
    $display("abort at beat 7: stb %0d ack %0d state %0d", sstb_a, ack_a, dbg_a);
    chk("abort_stb", sstb_a, 0);
    chk("abort_ack", ack_a, 0);
    chk("abort_state", dbg_a, 3'd0);
    chk("abort_beats", rlog_a.size() - n0, 8);
    req(0, 1'b0, 32'h3000, 512'h0, 64'h0, lat);
    $display("read 0x3000 after abort: ack latency %0d", lat);
    chk("post_abort_lat", lat, 18);
    chk("post_abort_data", dout_a, line_c3);

    // 64-bit x 8 geometry round trip.
    req(2, 1'b1, 32'h4000, line_c64, dm_all, lat);
    $display("wide write 0x4000: ack latency %0d", lat);
    chk("wide_wr_lat", lat, 9);
    chk("wide_wr_beats", wlog_c.size(), 8);
    for (int i = 0; i < 8; i++) chk("wide_wr_addr", wlog_c[i], 32'h4000 + 8*i);
    req(2, 1'b0, 32'h4000, 512'h0, 64'h0, lat);
    $display("wide read 0x4000: ack latency %0d", lat);
    chk("wide_rd_lat", lat, 10);
    chk("wide_rd_data", dout_c, line_c64);
    chk("wide_rd_addr7", rlog_c[7], 32'h4038);

    // Asynchronous reset in the middle of a write burst.
    @(negedge clk);
    cyc_a = 1; stb_a = 1; we_a = 1; addr_a = 32'h1000; din_a = line_a5; dm_a = dm_all;
    @(posedge clk); #1;
    stb_a = 0;
    repeat (5) @(negedge clk);
    chk("rst_mid_pre_state", dbg_a, 3'd1);
    #2 rst_n = 0;
    #1;
    $display("reset mid-write: stb %0d addr %0h state %0d", sstb_a, saddr_a, dbg_a);
    chk("rst_mid_stb", sstb_a, 0);
    chk("rst_mid_addr", saddr_a, 0);
    chk("rst_mid_dm", sdm_a, 0);
    chk("rst_mid_indata", sdin_a, 0);
    chk("rst_mid_ack", ack_a, 0);
    chk("rst_mid_dout", dout_a, 0);
    chk("rst_mid_state", dbg_a, 3'd0);
    cyc_a = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
